// File: rtl/loader_pkg.sv
// Shared definitions for the architectural-state loader: word width, default data-segment
// base, state encodings and the counter-width helper.
package loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_MEM_BASE = 32'h1001_0000;

  localparam logic [2:0] ST_LOAD_REG = 3'd0;
  localparam logic [2:0] ST_LOAD_MEM = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_HALT     = 3'd4;

  typedef enum logic [2:0] {
    StLoadReg = ST_LOAD_REG,
    StLoadMem = ST_LOAD_MEM,
    StDrain   = ST_DRAIN,
    StRun     = ST_RUN,
    StHalt    = ST_HALT
  } state_e;

  // Width needed to count 0..bound-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bound);
    return ($clog2(bound) < 1) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/word_counter.sv
// Up-counter with synchronous clear (dominant) and increment enable.
module word_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/state_loader.sv
// Streams words into the register file and data segment while holding the machine in reset,
// then releases it for a fixed number of cycles and freezes it again for the state dump.
module state_loader
  import loader_pkg::*;
#(
  parameter int unsigned       NUM_REGS   = 32,
  parameter int unsigned       MEM_WORDS  = 5,
  parameter int unsigned       RUN_CYCLES = 30,
  parameter logic [WORD_W-1:0] MEM_BASE   = DEFAULT_MEM_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              rf_wr_enable,
  output logic [4:0]        rf_wr_addr,
  output logic [WORD_W-1:0] rf_wr_data,
  output logic              mem_wr_enable,
  output logic [WORD_W-1:0] mem_wr_addr,
  output logic [WORD_W-1:0] mem_wr_data,
  output logic              machine_reset,
  output logic              done
);

  localparam int unsigned IDX_BOUND = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
  localparam int unsigned IDX_W     = cnt_width(IDX_BOUND);
  localparam int unsigned RUN_W     = cnt_width(RUN_CYCLES);

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUN_CYCLES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx;
  logic [RUN_W-1:0] run_cnt;

  logic in_load;
  logic transfer;
  logic last_reg;
  logic last_mem;
  logic run_last;
  logic idx_clear;
  logic run_clear;
  logic run_enable;

  assign in_load  = (state_q == StLoadReg) || (state_q == StLoadMem);
  assign in_ready = !reset && in_load;
  assign transfer = in_valid && in_ready;

  // The machine only leaves reset while the loader is running it.
  assign machine_reset = reset || (state_q != StRun);

  assign last_reg = (state_q == StLoadReg) && (idx == LAST_REG);
  assign last_mem = (state_q == StLoadMem) && (idx == LAST_MEM);
  assign run_last = (state_q == StRun) && (run_cnt == LAST_RUN);

  assign idx_clear  = reset || (transfer && (last_reg || last_mem));
  assign run_enable = (state_q == StRun);
  assign run_clear  = reset || !run_enable || run_last;

  word_counter #(
    .WIDTH (IDX_W)
  ) u_idx_counter (
    .clk    (clk),
    .clear  (idx_clear),
    .enable (transfer),
    .count  (idx)
  );

  word_counter #(
    .WIDTH (RUN_W)
  ) u_run_counter (
    .clk    (clk),
    .clear  (run_clear),
    .enable (run_enable),
    .count  (run_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StLoadReg;
      rf_wr_enable  <= 1'b0;
      rf_wr_addr    <= '0;
      rf_wr_data    <= '0;
      mem_wr_enable <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      done          <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; addresses and data hold their last value.
      rf_wr_enable  <= 1'b0;
      mem_wr_enable <= 1'b0;
      case (state_q)
        StLoadReg: begin
          if (transfer) begin
            rf_wr_addr   <= 5'(idx);
            rf_wr_data   <= in_data;
            rf_wr_enable <= (idx != '0);
            if (last_reg) begin
              state_q <= StLoadMem;
            end
          end
        end
        StLoadMem: begin
          if (transfer) begin
            mem_wr_addr   <= MEM_BASE + (WORD_W'(idx) << 2);
            mem_wr_data   <= in_data;
            mem_wr_enable <= 1'b1;
            if (last_mem) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          state_q <= StRun;
        end
        StRun: begin
          if (run_last) begin
            state_q <= StHalt;
            done    <= 1'b1;
          end
        end
        StHalt: begin
          done <= 1'b1;
        end
        default: begin
          state_q <= StLoadReg;
        end
      endcase
    end
  end

endmodule

// File: doc/state_loader.md
# state_loader

Loads the machine's architectural state before execution. It accepts a stream of 32-bit words, writes them into the register file and then into the data segment, and holds the machine in reset until the last write has committed. It then lets the machine run for a fixed number of cycles and freezes it again by reasserting machine reset, so the final state can be dumped. It is the write-side counterpart of the end-of-run register/memory dump: it sits between a host-side word source and the `rf` and `data_memory` write ports of `machine`.

## Interface
- `NUM_REGS`, 32: register-file words expected first; index 0 is consumed but never written.
- `MEM_WORDS`, 5: data-segment words expected after the registers.
- `MEM_BASE`, 32'h10010000: byte address of the first data word.
- `RUN_CYCLES`, 30: cycles the machine runs after loading.

Ports:
- `clk`  in  1  single clock, all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  source has a word.
- `in_data`  in  32  word to load.
- `in_ready`  out  1  loader accepts a word this cycle.
- `rf_wr_enable`  out  1  register-file write strobe.
- `rf_wr_addr`  out  5  register index.
- `rf_wr_data`  out  32  register value.
- `mem_wr_enable`  out  1  data-memory write strobe.
- `mem_wr_addr`  out  32  byte address, word-aligned.
- `mem_wr_data`  out  32  memory value.
- `machine_reset`  out  1  drives `machine` reset.
- `done`  out  1  run finished, state frozen; sticky until `reset`.

## Operation
- Reset values:
  - State: LOAD_REG.
  - Index and run counters: 0.
  - `in_ready`=0 during reset, and 1 from the first cycle after it.
  - All write strobes 0; all addresses and data 0.
  - `machine_reset`=1; `done`=0.
- States are LOAD_REG, LOAD_MEM, DRAIN, RUN and HALT.
- Transfer: a word transfers at a posedge with `in_valid && in_ready`. `in_ready`=1 only in LOAD_REG and LOAD_MEM, so one word per cycle is possible back-to-back.
- LOAD_REG:
  - On each transfer, register `rf_wr_addr`=idx, `rf_wr_data`=`in_data`, and `rf_wr_enable`=(idx!=0).
  - idx increments.
  - On the transfer at idx=NUM_REGS-1, go to LOAD_MEM with idx cleared.
- LOAD_MEM:
  - On each transfer, `mem_wr_addr`=MEM_BASE+(idx<<2), with 32-bit wrap and no overflow detection, `mem_wr_data`=`in_data`, `mem_wr_enable`=1.
  - On the transfer at idx=MEM_WORDS-1, go to DRAIN.
- DRAIN lasts one cycle while the final strobe commits. `machine_reset` is still 1. Then go to RUN.
- RUN:
  - `machine_reset`=0; the run counter increments each cycle.
  - At count RUN_CYCLES-1, go to HALT.
- HALT: `machine_reset`=1 and `done`=1, held indefinitely.
- `in_valid` outside the load states is ignored; no word is consumed.
- `in_data` is not sampled without a transfer.
- Reset asserted mid-load or mid-run aborts everything and returns to reset values on the next edge. Partially loaded state is not cleared; the source must restart from register 0.

## Timing
- Write latency: the strobe is high for exactly the one cycle after the accepting edge and commits at the following edge. Between transfers the strobes are 0.
- Stalls (`in_valid`=0) insert idle cycles with no effect on idx.
- Last memory word accepted at edge k:
  - Strobe high in cycle k..k+1.
  - State is DRAIN in that same cycle.
  - `machine_reset` falls after edge k+1.
  - The machine sees exactly RUN_CYCLES un-reset clock edges.
  - `done` and `machine_reset` rise after edge k+1+RUN_CYCLES.
- Minimum load time is NUM_REGS+MEM_WORDS cycles after reset release.
- Counter widths are $clog2 of the largest bound, at least 1 bit.

## Structure
- Shared package `loader_pkg`:
  - state encodings (3-bit localparams);
  - default MEM_BASE;
  - word width 32.
- One sub-module, `word_counter`: a synchronous-clear, enable-increment counter parameterised on width. It is instantiated twice, for idx and for run count.
- Output strobes, addresses and data are flopped. `in_ready` and `machine_reset` decode from state.

## Test plan
- Reset, then stream 32 words 0..31 followed by 5 words:
  - `rf_wr_enable` stays 0 for idx 0.
  - Registers 1..31 are written with 1..31.
  - `mem_wr_addr` runs 0x10010000..0x10010010.
- Random `in_valid` gaps: the same writes in the same order, one strobe per accepted word, and no strobe in gap cycles.
- Count from the final acceptance: `machine_reset` is low for exactly 30 cycles starting 2 edges after the last accept, then `done`=1 and `machine_reset`=1 and both stay there.
- `in_valid` held high during RUN/HALT: `in_ready`=0 and no writes occur.
- `reset` pulsed after 10 register words: outputs return to reset values, and the next word is written to register 0 (suppressed), then register 1.
- NUM_REGS=4, MEM_WORDS=1, RUN_CYCLES=1: `done` rises 7 edges after reset release with the source always valid.
